// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execution sequencer: opcodes, FSM states and
// the opcode classification rules.
package alu_pkg;

    localparam int DATA_W = 32;
    localparam int OP_W   = 4;

    localparam logic [OP_W-1:0] OP_SUB  = 4'b0001;
    localparam logic [OP_W-1:0] OP_MUL  = 4'b0010;
    localparam logic [OP_W-1:0] OP_DIV  = 4'b0011;
    localparam logic [OP_W-1:0] OP_SHL  = 4'b0100;
    localparam logic [OP_W-1:0] OP_SHR  = 4'b0101;
    localparam logic [OP_W-1:0] OP_SHRA = 4'b0110;
    localparam logic [OP_W-1:0] OP_NEG  = 4'b1010;
    localparam logic [OP_W-1:0] OP_NOT  = 4'b1011;
    localparam logic [OP_W-1:0] OP_ADD  = 4'b1101;
    localparam logic [OP_W-1:0] OP_NOP  = 4'b1111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_A,
        ST_LOAD_B,
        ST_EXEC,
        ST_CAPTURE,
        ST_WB_LO,
        ST_WB_HI
    } state_e;

    function automatic logic is_legal(input logic [OP_W-1:0] op);
        return !(op inside {4'b0000, 4'b1110, 4'b1111});
    endfunction

    // Single-operand ops read B only (negate/invert) or A only (shifts and 1100).
    function automatic logic uses_a(input logic [OP_W-1:0] op);
        return is_legal(op) && !(op inside {4'b1010, 4'b1011});
    endfunction

    function automatic logic uses_b(input logic [OP_W-1:0] op);
        return is_legal(op) && !(op inside {[4'b0100:4'b0111], 4'b1100});
    endfunction

    function automatic logic has_high(input logic [OP_W-1:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/alu_exec_sequencer_if.sv
// Handshake, operand bus and ALU-facing signals of the execution sequencer.
interface alu_exec_sequencer_if #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 4
);
    logic              start;
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] bus_in;
    logic              rx_out;
    logic              ry_out;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [OP_W-1:0]   alu_op;
    logic [DATA_W-1:0] alu_z_low;
    logic [DATA_W-1:0] alu_z_high;
    logic [DATA_W-1:0] result_lo;
    logic [DATA_W-1:0] result_hi;
    logic              rz_we;
    logic              hi_we;
    logic              busy;
    logic              done;
    logic              err;

    modport slave (
        input  start, op, bus_in, alu_z_low, alu_z_high,
        output rx_out, ry_out, alu_a, alu_b, alu_op,
               result_lo, result_hi, rz_we, hi_we, busy, done, err
    );

    modport master (
        output start, op, bus_in, alu_z_low, alu_z_high,
        input  rx_out, ry_out, alu_a, alu_b, alu_op,
               result_lo, result_hi, rz_we, hi_we, busy, done, err
    );
endinterface

// File: rtl/alu_op_class.sv
// Combinational opcode classifier: legality, operand usage and high-result flag.
module alu_op_class
    import alu_pkg::*;
(
    input  logic [OP_W-1:0] op,
    output logic            legal,
    output logic            use_a,
    output logic            use_b,
    output logic            high
);
    assign legal = is_legal(op);
    assign use_a = uses_a(op);
    assign use_b = uses_b(op);
    assign high  = has_high(op);
endmodule

// File: rtl/alu_exec_sequencer.sv
// Sequences operand fetch, ALU execution, result capture and writeback around
// an external ALU that only re-evaluates when its opcode changes.
module alu_exec_sequencer
    import alu_pkg::*;
#(
    parameter int              EXEC_CYCLES = 1,
    parameter logic [OP_W-1:0] NOP_OP      = OP_NOP
) (
    input  logic          clock,
    input  logic          clear,
    alu_exec_sequencer_if.slave sif
);
    localparam int              CNT_W    = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(EXEC_CYCLES - 1);

    state_e            state_q, state_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic              need_b_q, need_b_d;
    logic              hi_q, hi_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d;
    logic [DATA_W-1:0] alu_b_q, alu_b_d;
    logic [DATA_W-1:0] res_lo_q, res_lo_d;
    logic [DATA_W-1:0] res_hi_q, res_hi_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;

    logic op_legal, op_use_a, op_use_b, op_high;
    logic rx, ry, rz, hw, dn;
    logic [OP_W-1:0] alu_op;

    alu_op_class u_class (
        .op    (sif.op),
        .legal (op_legal),
        .use_a (op_use_a),
        .use_b (op_use_b),
        .high  (op_high)
    );

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q  <= ST_IDLE;
            op_q     <= NOP_OP;
            need_b_q <= 1'b0;
            hi_q     <= 1'b0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            res_lo_q <= '0;
            res_hi_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            need_b_q <= need_b_d;
            hi_q     <= hi_d;
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            res_lo_q <= res_lo_d;
            res_hi_q <= res_hi_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        need_b_d = need_b_q;
        hi_d     = hi_q;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        res_lo_d = res_lo_q;
        res_hi_d = res_hi_q;
        cnt_d    = cnt_q;
        err_d    = 1'b0;
        rx       = 1'b0;
        ry       = 1'b0;
        rz       = 1'b0;
        hw       = 1'b0;
        dn       = 1'b0;
        alu_op   = NOP_OP;

        case (state_q)
            ST_IDLE: begin
                if (sif.start) begin
                    if (!op_legal) begin
                        err_d = 1'b1;
                    end else begin
                        op_d     = sif.op;
                        need_b_d = op_use_b;
                        hi_d     = op_high;
                        // Unused operand is zeroed so the ALU never sees a stale value.
                        if (!op_use_a) alu_a_d = '0;
                        if (!op_use_b) alu_b_d = '0;
                        state_d  = op_use_a ? ST_LOAD_A : ST_LOAD_B;
                    end
                end
            end
            ST_LOAD_A: begin
                rx      = 1'b1;
                alu_a_d = sif.bus_in;
                if (need_b_q) begin
                    state_d = ST_LOAD_B;
                end else begin
                    state_d = ST_EXEC;
                    cnt_d   = CNT_INIT;
                end
            end
            ST_LOAD_B: begin
                ry      = 1'b1;
                alu_b_d = sif.bus_in;
                state_d = ST_EXEC;
                cnt_d   = CNT_INIT;
            end
            ST_EXEC: begin
                alu_op = op_q;
                if (cnt_q == '0) state_d = ST_CAPTURE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            ST_CAPTURE: begin
                res_lo_d = sif.alu_z_low;
                res_hi_d = sif.alu_z_high;
                state_d  = ST_WB_LO;
            end
            ST_WB_LO: begin
                rz      = 1'b1;
                dn      = !hi_q;
                state_d = hi_q ? ST_WB_HI : ST_IDLE;
            end
            ST_WB_HI: begin
                hw      = 1'b1;
                dn      = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign sif.rx_out    = rx;
    assign sif.ry_out    = ry;
    assign sif.alu_a     = alu_a_q;
    assign sif.alu_b     = alu_b_q;
    assign sif.alu_op    = alu_op;
    assign sif.result_lo = res_lo_q;
    assign sif.result_hi = res_hi_q;
    assign sif.rz_we     = rz;
    assign sif.hi_we     = hw;
    assign sif.busy      = (state_q != ST_IDLE);
    assign sif.done      = dn;
    assign sif.err       = err_q;

endmodule

// File: tb/tb_alu_exec_sequencer.sv
// Randomized self-checking bench for alu_exec_sequencer with a behavioural ALU
// and a transaction-level reference model of timing and results.
module tb_alu_exec_sequencer;
    localparam int         DW   = 32;
    localparam int         EXC  = 1;
    localparam logic [3:0] NOP  = 4'b1111;

    logic clock = 1'b0;
    logic clear = 1'b1;
    always #5 clock = ~clock;

    alu_exec_sequencer_if #(.DATA_W(DW), .OP_W(4)) sif ();

    alu_exec_sequencer #(.EXEC_CYCLES(EXC), .NOP_OP(NOP)) dut (
        .clock (clock),
        .clear (clear),
        .sif   (sif)
    );

    logic [DW-1:0] src_a = '0, src_b = '0;
    logic [DW-1:0] z_lo = '0, z_hi = '0;
    logic [3:0]    prev_op = NOP;
    int n_chk = 0, n_fail = 0;
    logic [DW-1:0] last_lo = '0, last_hi = '0;

    assign sif.bus_in     = sif.rx_out ? src_a : (sif.ry_out ? src_b : 32'hDEAD_BEEF);
    assign sif.alu_z_low  = z_lo;
    assign sif.alu_z_high = z_hi;

    function automatic logic [63:0] alu_ref(input logic [3:0] op, input logic [31:0] a, b);
        logic [63:0] p;
        case (op)
            4'b1101: return {32'h0, a + b};
            4'b0001: return {32'h0, a - b};
            4'b0010: begin p = 64'(a) * 64'(b); return p; end
            4'b0011: return (b == 0) ? 64'h0 : {a % b, a / b};
            4'b0100: return {32'h0, a << 1};
            4'b0101: return {32'h0, a >> 1};
            4'b0110: return {32'h0, 32'($signed(a) >>> 1)};
            4'b0111: return {32'h0, a[30:0], a[31]};
            4'b1000: return {32'h0, a & b};
            4'b1001: return {32'h0, a | b};
            4'b1010: return {32'h0, -b};
            4'b1011: return {32'h0, ~b};
            4'b1100: return {32'h0, ~a};
            default: return 64'h0;
        endcase
    endfunction

    // ALU re-evaluates only when its opcode changes to a real op.
    always @(negedge clock) begin
        if (sif.alu_op != prev_op && sif.alu_op != NOP)
            {z_hi, z_lo} = alu_ref(sif.alu_op, sif.alu_a, sif.alu_b);
        prev_op = sif.alu_op;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // poke: -1 none, 0 random cycle within the busy window, >0 fixed cycle for a second start.
    task automatic run_op(input logic [3:0] op_i, input logic [31:0] a_i, b_i, input int poke_in);
        logic legal, ua, ub, hi;
        logic [31:0] a_eff, b_eff, exp_lo, exp_hi;
        int exp_wb, exp_done, poke;
        int rx_n = 0, ry_n = 0, rz_n = 0, hi_n = 0, dn_n = 0, err_n = 0, busy_n = 0;
        int exec_n = 0, bad_op = 0, rz_c = -1, hi_c = -1, dn_c = -1, err_c = -1;

        legal = !(op_i inside {4'h0, 4'hE, 4'hF});
        ua    = legal && !(op_i inside {4'hA, 4'hB});
        ub    = legal && !(op_i inside {[4'h4:4'h7], 4'hC});
        hi    = (op_i == 4'h2) || (op_i == 4'h3);
        a_eff = ua ? a_i : 32'h0;
        b_eff = ub ? b_i : 32'h0;
        exp_wb   = int'(ua) + int'(ub) + EXC + 2;
        exp_done = exp_wb + int'(hi);
        poke = poke_in;
        if (!legal) poke = -1;
        else if (poke == 0) poke = $urandom_range(1, exp_done);
        if (legal) {exp_hi, exp_lo} = alu_ref(op_i, a_eff, b_eff);
        else begin exp_lo = last_lo; exp_hi = last_hi; end

        @(posedge clock); #1;
        sif.start = 1'b1; sif.op = op_i; src_a = a_i; src_b = b_i;
        for (int c = 0; c < 14; c++) begin
            if (c > 0) begin
                @(posedge clock); #1;
                sif.start = (c == poke);
                if (c == poke) sif.op = 4'h1;
            end
            @(negedge clock);
            if (sif.rx_out) rx_n++;
            if (sif.ry_out) ry_n++;
            if (sif.rz_we)  begin rz_n++;  rz_c = c;  end
            if (sif.hi_we)  begin hi_n++;  hi_c = c;  end
            if (sif.done)   begin dn_n++;  dn_c = c;  end
            if (sif.err)    begin err_n++; err_c = c; end
            if (sif.busy)   busy_n++;
            if (sif.alu_op != NOP) begin
                if (sif.alu_op == op_i && c == int'(ua) + int'(ub) + 1) exec_n++;
                else bad_op++;
            end
        end
        sif.start = 1'b0;

        if (legal) begin
            chk("rx_count", 64'(rx_n), 64'(ua));
            chk("ry_count", 64'(ry_n), 64'(ub));
            chk("rz_we_count", 64'(rz_n), 64'd1);
            chk("rz_we_cycle", 64'(rz_c), 64'(exp_wb));
            chk("hi_we_count", 64'(hi_n), 64'(hi));
            if (hi) chk("hi_we_cycle", 64'(hi_c), 64'(exp_wb + 1));
            chk("done_count", 64'(dn_n), 64'd1);
            chk("done_cycle", 64'(dn_c), 64'(exp_done));
            chk("err_count", 64'(err_n), 64'd0);
            chk("busy_cycles", 64'(busy_n), 64'(exp_done));
            chk("exec_op_cycles", 64'(exec_n), 64'(EXC));
            chk("stray_alu_op", 64'(bad_op), 64'd0);
            chk("alu_a", 64'(sif.alu_a), 64'(a_eff));
            chk("alu_b", 64'(sif.alu_b), 64'(b_eff));
        end else begin
            chk("err_count", 64'(err_n), 64'd1);
            chk("err_cycle", 64'(err_c), 64'd1);
            chk("illegal_busy", 64'(busy_n), 64'd0);
            chk("illegal_activity", 64'(rx_n + ry_n + rz_n + hi_n + dn_n + bad_op), 64'd0);
        end
        chk("result_lo", 64'(sif.result_lo), 64'(exp_lo));
        chk("result_hi", 64'(sif.result_hi), 64'(exp_hi));
        last_lo = exp_lo;
        last_hi = exp_hi;
    endtask

    initial begin
        int rz_n, dn_n, busy_n;
        logic [3:0] rop;
        logic [31:0] ra, rb;
        sif.start = 1'b0;
        sif.op    = 4'h0;

        repeat (2) @(negedge clock);
        chk("rst_alu_op", 64'(sif.alu_op), 64'(NOP));
        chk("rst_busy", 64'(sif.busy), 64'd0);
        chk("rst_alu_a", 64'(sif.alu_a), 64'd0);
        chk("rst_alu_b", 64'(sif.alu_b), 64'd0);
        chk("rst_results", {sif.result_hi, sif.result_lo}, 64'd0);
        chk("rst_strobes", 64'({sif.rz_we, sif.hi_we, sif.done, sif.err, sif.rx_out, sif.ry_out}), 64'd0);
        @(posedge clock); #1 clear = 1'b0;

        run_op(4'b1101, 32'd5, 32'd7, -1);
        chk("add_result", 64'(sif.result_lo), 64'hC);
        run_op(4'b0010, 32'h0001_0000, 32'h0001_0000, -1);
        chk("mul_result", {sif.result_hi, sif.result_lo}, {32'd1, 32'd0});
        run_op(4'b0011, 32'd17, 32'd5, -1);
        chk("div_result", {sif.result_hi, sif.result_lo}, {32'd2, 32'd3});
        run_op(4'b1011, 32'h1234_5678, 32'd0, -1);
        chk("not_result", 64'(sif.result_lo), 64'hFFFF_FFFF);
        run_op(4'b1110, 32'd1, 32'd2, -1);
        run_op(4'b1000, 32'hF0F0, 32'h0FF0, 2);
        run_op(4'b1101, 32'd9, 32'd1, 5);
        run_op(4'b0100, 32'h8000_0001, 32'h5555_5555, -1);

        // Asynchronous abort in the middle of EXEC.
        @(posedge clock); #1;
        sif.start = 1'b1; sif.op = 4'b0001; src_a = 32'd40; src_b = 32'd2;
        @(posedge clock); #1 sif.start = 1'b0;
        @(posedge clock);
        @(posedge clock); #2;
        chk("abort_pre_op", 64'(sif.alu_op), 64'h1);
        clear = 1'b1; #1;
        chk("abort_alu_op", 64'(sif.alu_op), 64'(NOP));
        chk("abort_operands", {sif.alu_a, sif.alu_b}, 64'd0);
        chk("abort_results", {sif.result_hi, sif.result_lo}, 64'd0);
        chk("abort_busy", 64'(sif.busy), 64'd0);
        @(posedge clock); #1 clear = 1'b0;
        last_lo = '0; last_hi = '0;
        rz_n = 0; dn_n = 0; busy_n = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            if (sif.rz_we || sif.hi_we) rz_n++;
            if (sif.done) dn_n++;
            if (sif.busy) busy_n++;
        end
        chk("abort_no_wb", 64'(rz_n + dn_n + busy_n), 64'd0);
        run_op(4'b0001, 32'd3, 32'd5, -1);
        chk("sub_after_abort", 64'(sif.result_lo), 64'hFFFF_FFFE);

        for (int i = 0; i < 40; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = $urandom;
            rb  = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 20)) : $urandom;
            run_op(rop, ra, rb, ($urandom_range(0, 3) == 0) ? 0 : -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
